// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared FSM encodings and GF(2^8) helpers for the AES decrypt-path stages
package aes_dec_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [6:0] {
        S_IDLE = 7'b0000001,
        S_RD01 = 7'b0000010,
        S_RD23 = 7'b0000100,
        S_COMP = 7'b0001000,
        S_WR01 = 7'b0010000,
        S_WR23 = 7'b0100000,
        S_DONE = 7'b1000000
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/gf_inv_mix_col.sv
// gf_inv_mix_col: combinational AES inverse MixColumns of one 4-byte column
module gf_inv_mix_col
    import aes_dec_pkg::*;
(
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] a3,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3
);

    assign r0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
    assign r1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
    assign r2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
    assign r3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);

endmodule

// File: rtl/inv_mix_column.sv
// inv_mix_column: in-place AES inverse MixColumns over the 16-entry statemt RAM, one column per 5 cycles
// Optional INV_MIX_COLUMN_RANGE_CHK_EN adds a sticky range_err flag for nonzero upper state bits.
module inv_mix_column
    import aes_dec_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
`ifdef INV_MIX_COLUMN_RANGE_CHK_EN
    output logic              range_err,
`endif
    output logic [ADDR_W-1:0] statemt_address0,
    output logic              statemt_ce0,
    output logic              statemt_we0,
    output logic [DATA_W-1:0] statemt_d0,
    input  logic [DATA_W-1:0] statemt_q0,
    output logic [ADDR_W-1:0] statemt_address1,
    output logic              statemt_ce1,
    output logic              statemt_we1,
    output logic [DATA_W-1:0] statemt_d1,
    input  logic [DATA_W-1:0] statemt_q1
);

    state_t     state, state_nxt;
    logic [1:0] col;
    logic [7:0] a0, a1, r0, r1, r2, r3;
    logic [7:0] m0, m1, m2, m3;
    logic       lo, hi, wr, accept;

    assign lo     = (state == S_RD01) || (state == S_WR01);
    assign hi     = (state == S_RD23) || (state == S_WR23);
    assign wr     = (state == S_WR01) || (state == S_WR23);
    assign accept = (state == S_IDLE) && ap_start;

    // a2/a3 come straight from the RAM outputs in COMP, so no capture register is spent on them
    gf_inv_mix_col u_mix (
        .a0(a0),
        .a1(a1),
        .a2(statemt_q0[7:0]),
        .a3(statemt_q1[7:0]),
        .r0(m0),
        .r1(m1),
        .r2(m2),
        .r3(m3)
    );

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state: fixed read/read/compute/write/write walk per column, four columns then DONE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = ap_start ? S_RD01 : S_IDLE;
            S_RD01:  state_nxt = S_RD23;
            S_RD23:  state_nxt = S_COMP;
            S_COMP:  state_nxt = S_WR01;
            S_WR01:  state_nxt = S_WR23;
            S_WR23:  state_nxt = (col == 2'd3) ? S_DONE : S_RD01;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: RAM ports are driven only in the read/write states, everything else held at 0
    always_comb begin
        statemt_ce0      = lo | hi;
        statemt_ce1      = lo | hi;
        statemt_we0      = wr;
        statemt_we1      = wr;
        statemt_address0 = lo ? ADDR_W'({col, 2'b00}) : hi ? ADDR_W'({col, 2'b10}) : '0;
        statemt_address1 = lo ? ADDR_W'({col, 2'b01}) : hi ? ADDR_W'({col, 2'b11}) : '0;
        statemt_d0       = (state == S_WR01) ? DATA_W'(r0) : (state == S_WR23) ? DATA_W'(r2) : '0;
        statemt_d1       = (state == S_WR01) ? DATA_W'(r1) : (state == S_WR23) ? DATA_W'(r3) : '0;
        ap_done          = (state == S_DONE);
        ap_ready         = (state == S_DONE);
        ap_idle          = (state == S_IDLE) && !ap_start;
    end

    // Datapath: column counter, first-pair capture and result registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            col <= '0;
            a0  <= '0;
            a1  <= '0;
            r0  <= '0;
            r1  <= '0;
            r2  <= '0;
            r3  <= '0;
        end else begin
            if (accept) col <= '0;
            if (state == S_WR23) col <= (col == 2'd3) ? col : col + 2'd1;
            if (state == S_RD23) begin
                a0 <= statemt_q0[7:0];
                a1 <= statemt_q1[7:0];
            end
            if (state == S_COMP) begin
                r0 <= m0;
                r1 <= m1;
                r2 <= m2;
                r3 <= m3;
            end
        end
    end

`ifdef INV_MIX_COLUMN_RANGE_CHK_EN
    logic q_hi;

    assign q_hi = (|statemt_q0[DATA_W-1:8]) | (|statemt_q1[DATA_W-1:8]);

    // Sticky flag: any word read this run carried nonzero bits above the state byte
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)                                            range_err <= 1'b0;
        else if (accept)                                          range_err <= 1'b0;
        else if (((state == S_RD23) || (state == S_COMP)) && q_hi) range_err <= 1'b1;
    end
`else
    logic unused_q_hi;

    assign unused_q_hi = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};
`endif

endmodule
